// File: rtl/uart_rx_byte.sv
// uart_rx_byte: oversampling 8N1 UART receiver with majority-vote bit decisions.
// Define UART_RX_PARITY_EN to receive 8E1 frames; bad parity raises RxD_frame_err.
module uart_rx_byte #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_idle,
  output logic       RxD_frame_err
);
  localparam int DIV = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP, BREAK
  } state_t;
  state_t state, state_nxt;
  logic rx_meta, rxs, rxs_q;
  logic [CW-1:0] cnt;
  logic [SW-1:0] s;
  logic [2:0] idx;
  logic [7:0] sr;
  logic m0, m1, maj, tick, decide, wrap, perr, ok, err, ok_q, err_q;
`ifdef UART_RX_PARITY_EN
  logic par;
  assign perr = ^{sr, par};
`else
  assign perr = 1'b0;
`endif
  assign tick     = state != IDLE && cnt == CW'(DIV - 1);
  assign decide   = tick && s == SW'(MID + 1);
  assign wrap     = tick && s == SW'(OVERSAMPLE - 1);
  assign maj      = (m0 & m1) | (m0 & rxs) | (m1 & rxs);
  assign RxD_idle = state == IDLE;
  always_ff @(posedge clk)
    if (rst) {rx_meta, rxs, rxs_q} <= '1;
    else {rx_meta, rxs, rxs_q} <= {RxD, rx_meta, rxs};
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    ok = 1'b0;
    err = 1'b0;
    case (state)
      IDLE:  state_nxt = !rxs && rxs_q ? START : IDLE;
      START: state_nxt = decide && maj ? IDLE : wrap ? DATA : START;
`ifdef UART_RX_PARITY_EN
      DATA:   state_nxt = wrap && idx == 3'd7 ? PARITY : DATA;
      PARITY: state_nxt = wrap ? STOP : PARITY;
`else
      DATA:  state_nxt = wrap && idx == 3'd7 ? STOP : DATA;
`endif
      STOP: if (decide) begin
        ok = maj & ~perr;
        err = ~maj | perr;
        state_nxt = maj ? IDLE : BREAK;
      end
      BREAK: state_nxt = rxs ? IDLE : BREAK;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst || state == IDLE || tick) cnt <= '0;
    else cnt <= cnt + CW'(1);
  always_ff @(posedge clk)
    if (rst || state == IDLE) s <= '0;
    else if (tick) s <= wrap ? '0 : s + SW'(1);
  // Samples either side of mid-bit feed the 2-of-3 vote with the current rxs.
  always_ff @(posedge clk)
    if (rst) {m0, m1} <= '0;
    else if (tick) begin
      if (s == SW'(MID - 1)) m0 <= rxs;
      if (s == SW'(MID)) m1 <= rxs;
    end
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      sr <= '0;
    end else begin
      if (state == START) idx <= '0;
      else if (state == DATA && wrap) idx <= idx + 3'd1;
      if (state == DATA && decide) sr[idx] <= maj;
    end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk)
    if (rst) par <= 1'b0;
    else if (state == PARITY && decide) par <= maj;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      {ok_q, err_q, RxD_data_ready, RxD_frame_err} <= '0;
      RxD_data <= '0;
    end else begin
      {ok_q, err_q} <= {ok, err};
      {RxD_data_ready, RxD_frame_err} <= {ok_q, err_q};
      if (ok_q) RxD_data <= sr;
    end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed frames against uart_rx_byte at 50 MHz / 115200 baud (27 clks per tick).
module tb_uart_rx_byte;
  localparam int BT = 16 * 27;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = PAR ? 11 : 10;
  logic clk = 1'b0, rst = 1'b1, RxD = 1'b1;
  logic [7:0] RxD_data;
  logic RxD_data_ready, RxD_idle, RxD_frame_err;
  int passed = 0, total = 0, cyc = 0, n_err = 0, n_both = 0;
  logic [7:0] rdy_data[$];
  int rdy_cyc[$];

  uart_rx_byte dut (
    .clk(clk), .rst(rst), .RxD(RxD), .RxD_data(RxD_data),
    .RxD_data_ready(RxD_data_ready), .RxD_idle(RxD_idle), .RxD_frame_err(RxD_frame_err)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    if (RxD_data_ready) begin
      rdy_data.push_back(RxD_data);
      rdy_cyc.push_back(cyc);
    end
    if (RxD_frame_err) n_err++;
    if (RxD_data_ready && RxD_frame_err) n_both++;
  end

  task automatic send_bit(input logic b, input int n);
    RxD = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
    send_bit(1'b0, BT);
    for (int i = 0; i < 8; i++) send_bit(d[i], BT);
    if (PAR) send_bit(^d ^ flip, BT);
    send_bit(stop, BT);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (RxD_data !== 8'h00) $display("FAIL reset_data got %h want 00", RxD_data); else passed++;
    total++; if (RxD_data_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", RxD_data_ready); else passed++;
    total++; if (RxD_frame_err !== 1'b0) $display("FAIL reset_err got %b want 0", RxD_frame_err); else passed++;
    total++; if (RxD_idle !== 1'b1) $display("FAIL reset_idle got %b want 1", RxD_idle); else passed++;
  endtask

  task automatic test_single;
    int n0, e0;
    n0 = rdy_data.size(); e0 = n_err;
    send_frame(8'h41, 1'b1, 1'b0);
    send_bit(1'b1, BT);
    total++; if (rdy_data.size() - n0 !== 1) $display("FAIL single_ready_count got %0d want 1", rdy_data.size() - n0); else passed++;
    total++; if (RxD_data !== 8'h41) $display("FAIL single_data got %h want 41", RxD_data); else passed++;
    total++; if (n_err - e0 !== 0) $display("FAIL single_err_count got %0d want 0", n_err - e0); else passed++;
    total++; if (RxD_idle !== 1'b1) $display("FAIL single_idle got %b want 1", RxD_idle); else passed++;
  endtask

  task automatic test_back_to_back;
    int n0, sp;
    n0 = rdy_data.size();
    send_frame(8'h0D, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    send_bit(1'b1, BT);
    total++; if (rdy_data.size() - n0 !== 2) $display("FAIL b2b_ready_count got %0d want 2", rdy_data.size() - n0); else passed++;
    if (rdy_data.size() >= n0 + 2) begin
      sp = rdy_cyc[n0 + 1] - rdy_cyc[n0];
      total++; if (rdy_data[n0] !== 8'h0D) $display("FAIL b2b_first got %h want 0d", rdy_data[n0]); else passed++;
      total++; if (rdy_data[n0 + 1] !== 8'h55) $display("FAIL b2b_second got %h want 55", rdy_data[n0 + 1]); else passed++;
      total++;
      if (sp < FRAME * BT - 27 || sp > FRAME * BT + 27) $display("FAIL b2b_spacing got %0d want %0d+-27", sp, FRAME * BT);
      else passed++;
    end
  endtask

  task automatic test_glitch;
    int n0, e0;
    n0 = rdy_data.size(); e0 = n_err;
    send_bit(1'b0, 3);
    send_bit(1'b1, 3);
    total++; if (RxD_idle !== 1'b0) $display("FAIL glitch_start_seen got idle=%b want 0", RxD_idle); else passed++;
    send_bit(1'b1, BT);
    total++; if (RxD_idle !== 1'b1) $display("FAIL glitch_idle got %b want 1", RxD_idle); else passed++;
    total++; if (rdy_data.size() - n0 + n_err - e0 !== 0) $display("FAIL glitch_strobes got %0d want 0", rdy_data.size() - n0 + n_err - e0); else passed++;
    total++; if (RxD_data !== 8'h55) $display("FAIL glitch_data got %h want 55", RxD_data); else passed++;
  endtask

  task automatic test_break;
    int n0, e0;
    n0 = rdy_data.size(); e0 = n_err;
    send_frame(8'hA5, 1'b0, 1'b0);
    send_bit(1'b0, 3 * BT);
    send_bit(1'b1, 2 * BT);
    total++; if (n_err - e0 !== 1) $display("FAIL break_err_count got %0d want 1", n_err - e0); else passed++;
    total++; if (rdy_data.size() - n0 !== 0) $display("FAIL break_ready_count got %0d want 0", rdy_data.size() - n0); else passed++;
    total++; if (RxD_data !== 8'h55) $display("FAIL break_data_held got %h want 55", RxD_data); else passed++;
    send_frame(8'h31, 1'b1, 1'b0);
    send_bit(1'b1, BT);
    total++; if (rdy_data.size() - n0 !== 1) $display("FAIL break_recover_count got %0d want 1", rdy_data.size() - n0); else passed++;
    total++; if (RxD_data !== 8'h31) $display("FAIL break_recover_data got %h want 31", RxD_data); else passed++;
    total++; if (n_err - e0 !== 1) $display("FAIL break_err_total got %0d want 1", n_err - e0); else passed++;
  endtask

  task automatic test_rst_abort;
    int n0, e0;
    n0 = rdy_data.size(); e0 = n_err;
    send_bit(1'b0, BT);
    send_bit(1'b1, 4 * BT + BT / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (RxD_data !== 8'h00) $display("FAIL abort_data got %h want 00", RxD_data); else passed++;
    total++; if (RxD_idle !== 1'b1) $display("FAIL abort_idle got %b want 1", RxD_idle); else passed++;
    send_bit(1'b1, 6 * BT);
    total++; if (rdy_data.size() - n0 + n_err - e0 !== 0) $display("FAIL abort_strobes got %0d want 0", rdy_data.size() - n0 + n_err - e0); else passed++;
    send_frame(8'h12, 1'b1, 1'b0);
    send_bit(1'b1, BT);
    total++; if (rdy_data.size() - n0 !== 1) $display("FAIL abort_next_count got %0d want 1", rdy_data.size() - n0); else passed++;
    total++; if (RxD_data !== 8'h12) $display("FAIL abort_next_data got %h want 12", RxD_data); else passed++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int n0, e0;
    n0 = rdy_data.size(); e0 = n_err;
    send_frame(8'h03, 1'b1, 1'b0);
    send_bit(1'b1, BT);
    total++; if (rdy_data.size() - n0 !== 1) $display("FAIL parity_good_count got %0d want 1", rdy_data.size() - n0); else passed++;
    total++; if (RxD_data !== 8'h03) $display("FAIL parity_good_data got %h want 03", RxD_data); else passed++;
    send_frame(8'h03, 1'b1, 1'b1);
    send_bit(1'b1, BT);
    total++; if (n_err - e0 !== 1) $display("FAIL parity_bad_err got %0d want 1", n_err - e0); else passed++;
    total++; if (rdy_data.size() - n0 !== 1) $display("FAIL parity_bad_ready got %0d want 1", rdy_data.size() - n0); else passed++;
    total++; if (RxD_data !== 8'h03) $display("FAIL parity_bad_data got %h want 03", RxD_data); else passed++;
  endtask
`endif

  initial begin
    #(20 * 95000);
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_break;
    test_rst_abort;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    total++; if (n_both !== 0) $display("FAIL strobe_overlap got %0d want 0", n_both); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
